// File: rtl/acl_pkg.sv
// acl_pkg: command codes, register addresses and FSM states for the accelerometer SPI responder
package acl_pkg;
  localparam logic [7:0] CMD_READ  = 8'h0B;
  localparam logic [7:0] CMD_WRITE = 8'h0A;
  localparam logic [5:0] ADDR_DEVID_AD  = 6'h00;
  localparam logic [5:0] ADDR_DEVID_MST = 6'h01;
  localparam logic [5:0] ADDR_PARTID    = 6'h02;
  localparam logic [5:0] ADDR_XDATA_L   = 6'h0E;
  localparam logic [5:0] ADDR_XDATA_H   = 6'h0F;
  localparam logic [5:0] ADDR_YDATA_L   = 6'h10;
  localparam logic [5:0] ADDR_YDATA_H   = 6'h11;
  localparam logic [5:0] ADDR_ZDATA_L   = 6'h12;
  localparam logic [5:0] ADDR_ZDATA_H   = 6'h13;
  localparam logic [5:0] ADDR_FILTER_CTL = 6'h2C;
  localparam logic [5:0] ADDR_POWER_CTL  = 6'h2D;
  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DATA, S_IGNORE} state_e;
endpackage

// File: rtl/acl_spi_responder_if.sv
// acl_spi_responder_if: SPI pin bundle between a master and the responder
interface acl_spi_responder_if;
  logic sclk;
  logic mosi;
  logic csn;
  logic miso;
  modport master (output sclk, mosi, csn, input miso);
  modport slave (input sclk, mosi, csn, output miso);
endinterface

// File: rtl/acl_spi_responder_sync.sv
// spi_pin_sync: multi-flop synchronizer with one extra flop for rise/fall detection
module spi_pin_sync #(
  parameter int W = 3,
  parameter int STAGES = 2
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] level,
  output logic [W-1:0] rise,
  output logic [W-1:0] fall
);
  logic [STAGES:0][W-1:0] chain_q, chain_d;
  always_comb chain_d = {chain_q[STAGES-1:0], d};
  // Reset to all-zero so a csn held low through reset never yields a fall_csn
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) chain_q <= '0;
    else chain_q <= chain_d;
  assign level = chain_q[STAGES-1];
  assign rise  = level & ~chain_q[STAGES];
  assign fall  = ~level & chain_q[STAGES];
endmodule

// File: rtl/acl_spi_responder.sv
// acl_spi_responder: SPI mode-0 slave emulating the accelerometer register map, oversampled in Clk
module acl_spi_responder
  import acl_pkg::*;
#(
  parameter logic [7:0] DEVID_AD  = 8'hAD,
  parameter logic [7:0] DEVID_MST = 8'h1D,
  parameter logic [7:0] PARTID    = 8'hF2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       Clk,
  input  logic                       Reset,
  acl_spi_responder_if.slave         spi,
  input  logic [11:0]                x_data,
  input  logic [11:0]                y_data,
  input  logic [11:0]                z_data,
  output logic [7:0]                 power_ctl,
  output logic [7:0]                 filter_ctl,
  output logic                       xfer_done,
  output logic                       cmd_err
);
  logic [2:0] lvl, rise, fall;
  spi_pin_sync #(.W(3), .STAGES(SYNC_STAGES)) u_sync (
    .Clk(Clk), .Reset(Reset), .d({spi.sclk, spi.mosi, spi.csn}),
    .level(lvl), .rise(rise), .fall(fall)
  );
  logic unused_sync;
  assign unused_sync = ^{lvl[2], lvl[0], rise[1], fall[1]};
  logic rise_sclk, fall_sclk, fall_csn, rise_csn, mosi_s;
  assign rise_sclk = rise[2];
  assign fall_sclk = fall[2];
  assign rise_csn  = rise[0];
  assign fall_csn  = fall[0];
  assign mosi_s    = lvl[1];
  state_e state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] sh_q, sh_d;
  logic [5:0] addr_q, addr_d;
  logic [7:0] tx_q, tx_d, power_q, power_d, filter_q, filter_d;
  logic [15:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic rw_q, rw_d, miso_q, miso_d, seen_q, seen_d, xfer_q, xfer_d, err_q, err_d;
  logic [7:0] byte_in;
  logic [5:0] addr_inc;
  logic byte_done, cmd_ok;
  assign byte_in   = {sh_q, mosi_s};
  assign addr_inc  = addr_q + 6'd1;
  assign byte_done = rise_sclk && bit_cnt_q == 3'd7;
  assign cmd_ok    = byte_in == CMD_READ || byte_in == CMD_WRITE;
  function automatic logic [7:0] reg_rd(input logic [5:0] a, input logic [15:0] x, y, z,
                                        input logic [7:0] fc, pc);
    case (a)
      ADDR_DEVID_AD:   reg_rd = DEVID_AD;
      ADDR_DEVID_MST:  reg_rd = DEVID_MST;
      ADDR_PARTID:     reg_rd = PARTID;
      ADDR_XDATA_L:    reg_rd = x[7:0];
      ADDR_XDATA_H:    reg_rd = x[15:8];
      ADDR_YDATA_L:    reg_rd = y[7:0];
      ADDR_YDATA_H:    reg_rd = y[15:8];
      ADDR_ZDATA_L:    reg_rd = z[7:0];
      ADDR_ZDATA_H:    reg_rd = z[15:8];
      ADDR_FILTER_CTL: reg_rd = fc;
      ADDR_POWER_CTL:  reg_rd = pc;
      default:         reg_rd = 8'h00;
    endcase
  endfunction
  always_comb begin
    state_d = state_q;
    bit_cnt_d = bit_cnt_q;
    sh_d = sh_q;
    addr_d = addr_q;
    tx_d = tx_q;
    power_d = power_q;
    filter_d = filter_q;
    x_d = x_q;
    y_d = y_q;
    z_d = z_q;
    rw_d = rw_q;
    miso_d = miso_q;
    seen_d = seen_q;
    xfer_d = 1'b0;
    err_d = 1'b0;
    // csn rising beats a coincident sclk rise: the partial bit is dropped
    if (rise_csn) begin
      state_d = S_IDLE;
      miso_d = 1'b0;
      xfer_d = seen_q;
      seen_d = 1'b0;
    end else if (state_q == S_IDLE) begin
      if (fall_csn) begin
        state_d = S_CMD;
        bit_cnt_d = '0;
        sh_d = '0;
        seen_d = 1'b0;
        miso_d = 1'b0;
        x_d = {{4{x_data[11]}}, x_data};
        y_d = {{4{y_data[11]}}, y_data};
        z_d = {{4{z_data[11]}}, z_data};
      end
    end else if (state_q != S_IGNORE) begin
      if (rise_sclk) begin
        sh_d = byte_in[6:0];
        bit_cnt_d = bit_cnt_q + 3'd1;
      end
      if (fall_sclk && state_q == S_DATA && rw_q) begin
        miso_d = tx_q[7];
        tx_d = {tx_q[6:0], 1'b0};
      end
      if (byte_done && state_q == S_CMD) begin
        rw_d = byte_in == CMD_READ;
        state_d = cmd_ok ? S_ADDR : S_IGNORE;
        err_d = !cmd_ok;
      end else if (byte_done && state_q == S_ADDR) begin
        addr_d = byte_in[5:0];
        tx_d = reg_rd(byte_in[5:0], x_q, y_q, z_q, filter_q, power_q);
        state_d = S_DATA;
      end else if (byte_done) begin
        seen_d = 1'b1;
        addr_d = addr_inc;
        tx_d = reg_rd(addr_inc, x_q, y_q, z_q, filter_q, power_q);
        filter_d = (!rw_q && addr_q == ADDR_FILTER_CTL) ? byte_in : filter_q;
        power_d = (!rw_q && addr_q == ADDR_POWER_CTL) ? byte_in : power_q;
      end
    end
  end
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      state_q <= S_IDLE;
      bit_cnt_q <= '0;
      sh_q <= '0;
      addr_q <= '0;
      tx_q <= '0;
      power_q <= '0;
      filter_q <= '0;
      x_q <= '0;
      y_q <= '0;
      z_q <= '0;
      rw_q <= 1'b0;
      miso_q <= 1'b0;
      seen_q <= 1'b0;
      xfer_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_cnt_q <= bit_cnt_d;
      sh_q <= sh_d;
      addr_q <= addr_d;
      tx_q <= tx_d;
      power_q <= power_d;
      filter_q <= filter_d;
      x_q <= x_d;
      y_q <= y_d;
      z_q <= z_d;
      rw_q <= rw_d;
      miso_q <= miso_d;
      seen_q <= seen_d;
      xfer_q <= xfer_d;
      err_q <= err_d;
    end
  assign spi.miso   = miso_q;
  assign power_ctl  = power_q;
  assign filter_ctl = filter_q;
  assign xfer_done  = xfer_q;
  assign cmd_err    = err_q;
endmodule

// File: tb/tb_acl_spi_responder.sv
// tb_acl_spi_responder: directed SPI transactions with a pin-level monitor checking read bytes from a queue
module tb_acl_spi_responder;
  logic Clk = 1'b0;
  logic Reset = 1'b1;
  logic [11:0] x_data, y_data, z_data;
  logic [7:0] power_ctl, filter_ctl;
  logic xfer_done, cmd_err;
  acl_spi_responder_if spi();
  acl_spi_responder dut (
    .Clk(Clk), .Reset(Reset), .spi(spi),
    .x_data(x_data), .y_data(y_data), .z_data(z_data),
    .power_ctl(power_ctl), .filter_ctl(filter_ctl),
    .xfer_done(xfer_done), .cmd_err(cmd_err)
  );
  always #5 Clk = ~Clk;
  int n_chk = 0;
  int n_fail = 0;
  int xfer_cnt = 0;
  int err_cnt = 0;
  logic [7:0] exp_q[$];
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge Clk) begin
    if (xfer_done === 1'b1) xfer_cnt++;
    if (cmd_err === 1'b1) err_cnt++;
  end
  // Monitor: decodes each transaction from the pins; read data bytes are checked against the queue
  int bitn = 0;
  logic [7:0] mo_sh = '0, mi_sh = '0, cmd_b = '0;
  always @(posedge spi.sclk or posedge spi.csn) begin
    if (spi.csn) bitn = 0;
    else begin
      mo_sh = {mo_sh[6:0], spi.mosi};
      mi_sh = {mi_sh[6:0], spi.miso};
      bitn++;
      if (bitn % 8 == 0) begin
        if (bitn == 8) cmd_b = mo_sh;
        if (bitn > 16 && cmd_b == 8'h0B) begin
          if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL rd_byte: got %h with no expected byte queued", mi_sh);
          end else chk("rd_byte", {8'h00, mi_sh}, {8'h00, exp_q.pop_front()});
        end else chk("miso_quiet_byte", {8'h00, mi_sh}, 16'h0000);
      end
    end
  end
  task automatic hp();
    repeat (8) @(negedge Clk);
  endtask
  task automatic bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      spi.mosi = b[7-i];
      hp();
      spi.sclk = 1'b1;
      hp();
      spi.sclk = 1'b0;
    end
  endtask
  task automatic start();
    spi.csn = 1'b0;
    hp();
  endtask
  task automatic stop();
    hp();
    spi.csn = 1'b1;
    hp();
    hp();
  endtask
  task automatic rd(input logic [7:0] a, input int n);
    start();
    bits(8'h0B, 8);
    bits(a, 8);
    for (int i = 0; i < n; i++) bits(8'h00, 8);
    stop();
  endtask
  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    start();
    bits(8'h0A, 8);
    bits(a, 8);
    bits(d, 8);
    stop();
  endtask
  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    int xb, eb;
    spi.csn = 1'b1;
    spi.sclk = 1'b0;
    spi.mosi = 1'b0;
    x_data = '0;
    y_data = '0;
    z_data = '0;
    repeat (3) @(negedge Clk);
    chk("reset_miso", {15'd0, spi.miso}, 16'h0000);
    chk("reset_power", {8'h00, power_ctl}, 16'h0000);
    chk("reset_filter", {8'h00, filter_ctl}, 16'h0000);
    chk("reset_pulses", {14'd0, xfer_done, cmd_err}, 16'h0000);
    Reset = 1'b0;
    repeat (10) @(negedge Clk);
    chk("no_pulse_after_reset", 16'(xfer_cnt + err_cnt), 16'd0);
    exp_q.push_back(8'hAD);
    exp_q.push_back(8'h1D);
    exp_q.push_back(8'hF2);
    rd(8'h00, 3);
    chk("read_id_xfer_done", 16'(xfer_cnt), 16'd1);
    x_data = 12'h800;
    y_data = 12'h7FF;
    z_data = 12'h001;
    foreach (exp_q[i]) exp_q.delete(i);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hF8);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h07);
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h00);
    start();
    bits(8'h0B, 8);
    bits(8'h0E, 8);
    bits(8'h00, 8);
    x_data = 12'h123;
    for (int i = 0; i < 5; i++) bits(8'h00, 8);
    stop();
    chk("burst_xfer_done", 16'(xfer_cnt), 16'd2);
    wr(8'h2D, 8'h02);
    chk("write_power", {8'h00, power_ctl}, 16'h0002);
    chk("write_xfer_done", 16'(xfer_cnt), 16'd3);
    exp_q.push_back(8'h02);
    rd(8'h2D, 1);
    wr(8'h20, 8'h55);
    exp_q.push_back(8'h00);
    rd(8'h20, 1);
    chk("ro_write_power_kept", {8'h00, power_ctl}, 16'h0002);
    xb = xfer_cnt;
    eb = err_cnt;
    start();
    bits(8'h0C, 8);
    bits(8'h00, 8);
    bits(8'h00, 8);
    stop();
    chk("bad_cmd_err", 16'(err_cnt - eb), 16'd1);
    chk("bad_cmd_no_xfer", 16'(xfer_cnt - xb), 16'd0);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hAD);
    rd(8'h3F, 2);
    wr(8'h2C, 8'h33);
    chk("write_filter", {8'h00, filter_ctl}, 16'h0033);
    xb = xfer_cnt;
    start();
    bits(8'h0A, 8);
    bits(8'h2C, 8);
    bits(8'hFF, 4);
    stop();
    chk("abort_filter_kept", {8'h00, filter_ctl}, 16'h0033);
    chk("abort_no_xfer", 16'(xfer_cnt - xb), 16'd0);
    exp_q.push_back(8'h33);
    rd(8'h2C, 1);
    exp_q.push_back(8'h02);
    xb = xfer_cnt;
    start();
    bits(8'h0B, 8);
    bits(8'h2D, 8);
    bits(8'h00, 8);
    bits(8'h00, 3);
    Reset = 1'b1;
    #1;
    chk("async_reset_miso", {15'd0, spi.miso}, 16'h0000);
    chk("async_reset_power", {8'h00, power_ctl}, 16'h0000);
    chk("async_reset_filter", {8'h00, filter_ctl}, 16'h0000);
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    bits(8'h00, 1);
    stop();
    chk("reset_abort_no_xfer", 16'(xfer_cnt - xb), 16'd0);
    exp_q.push_back(8'hAD);
    exp_q.push_back(8'h1D);
    exp_q.push_back(8'hF2);
    rd(8'h00, 3);
    chk("post_reset_xfer_done", 16'(xfer_cnt - xb), 16'd1);
    chk("queue_drained", 16'(exp_q.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
